acia_stream_buffer: RTL

Byte buffer between the MUACM USB-CDC core's 8-bit valid/ready streams and `cpu_system`'s `rx_*`/`tx_*` ports. It provides an RX FIFO (USB→CPU) and a TX FIFO (CPU→USB), so the 6502 ACIA never stalls the USB endpoint on short bursts. The TX side batches bytes into bursts, released on a fill threshold or an idle timeout, to cut USB packet overhead.

---
 rtl/acia_stream_buffer_if.sv | 39 +++
 rtl/acia_stream_buffer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/acia_stream_buffer_if.sv
// Stream-side bundle between the MUACM USB-CDC core, the buffer and cpu_system.
// slave is the buffer's view; master is the surrounding system's view.
interface acia_stream_buffer_if #(
    parameter int RX_AW = 4,
    parameter int TX_AW = 4
);
    logic [7:0]     usb_rx_data;
    logic           usb_rx_val;
    logic           usb_rx_rdy;
    logic [7:0]     cpu_rx_data;
    logic           cpu_rx_val;
    logic           cpu_rx_rdy;
    logic [7:0]     cpu_tx_data;
    logic           cpu_tx_val;
    logic           cpu_tx_rdy;
    logic [7:0]     usb_tx_data;
    logic           usb_tx_val;
    logic           usb_tx_rdy;
    logic           flush;
    logic [RX_AW:0] rx_level;
    logic [TX_AW:0] tx_level;
    logic           rx_ovf;

    modport slave (
        input  usb_rx_data, usb_rx_val, cpu_rx_rdy,
        input  cpu_tx_data, cpu_tx_val, usb_tx_rdy, flush,
        output usb_rx_rdy, cpu_rx_data, cpu_rx_val,
        output cpu_tx_rdy, usb_tx_data, usb_tx_val,
        output rx_level, tx_level, rx_ovf
    );

    modport master (
        output usb_rx_data, usb_rx_val, cpu_rx_rdy,
        output cpu_tx_data, cpu_tx_val, usb_tx_rdy, flush,
        input  usb_rx_rdy, cpu_rx_data, cpu_rx_val,
        input  cpu_tx_rdy, usb_tx_data, usb_tx_val,
        input  rx_level, tx_level, rx_ovf
    );
endinterface

// File: rtl/acia_stream_buffer.sv
// RX (USB->CPU) and TX (CPU->USB) byte FIFOs between MUACM and the 6502 ACIA.
// TX holds bytes back until a fill threshold or an idle timeout, then drains as a burst.
module acia_stream_buffer #(
    parameter int RX_AW    = 4,
    parameter int TX_AW    = 4,
    parameter int TX_BURST = 8,
    parameter int TX_IDLE  = 255
) (
    input logic                 clk,
    input logic                 rst,
    acia_stream_buffer_if.slave bus
);
    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;
    localparam logic [RX_AW:0] RX_FULL   = {1'b1, {RX_AW{1'b0}}};
    localparam logic [TX_AW:0] TX_FULL   = {1'b1, {TX_AW{1'b0}}};
    localparam logic [RX_AW:0] RX_ZERO   = {(RX_AW+1){1'b0}};
    localparam logic [TX_AW:0] TX_ZERO   = {(TX_AW+1){1'b0}};
    localparam logic [TX_AW:0] TX_BURST_L = TX_BURST[TX_AW:0];
    localparam logic [15:0]    TX_IDLE_L  = TX_IDLE[15:0];

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } tx_state_t;

    logic [7:0]       rx_mem_r [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr_r, rx_rd_ptr_r, rx_rd_sel_s;
    logic [RX_AW:0]   rx_level_r, rx_old_s, rx_level_nxt_s;
    logic             rx_push_s, rx_pop_s;
    logic [7:0]       rx_data_r;
    logic             rx_val_r, rx_rdy_r, rx_ovf_r;

    logic [7:0]       tx_mem_r [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr_r, tx_rd_ptr_r, tx_rd_sel_s;
    logic [TX_AW:0]   tx_level_r, tx_old_s, tx_level_nxt_s;
    logic             tx_push_s, tx_pop_s;
    logic [7:0]       tx_data_r, tx_head_s;
    logic             tx_val_r, tx_rdy_r;
    logic [15:0]      tx_idle_cnt_r;
    tx_state_t        tx_state_r, tx_state_nxt_s;

    // RX handshake decode; tx_old_s/rx_old_s count entries that survive this edge's pop
    always_comb begin
        rx_push_s      = bus.usb_rx_val && (rx_level_r != RX_FULL) && !bus.flush;
        rx_pop_s       = bus.cpu_rx_rdy && rx_val_r && !bus.flush;
        rx_old_s       = rx_level_r - (RX_AW+1)'(rx_pop_s);
        rx_level_nxt_s = rx_old_s + (RX_AW+1)'(rx_push_s);
        rx_rd_sel_s    = rx_rd_ptr_r + RX_AW'(rx_pop_s);
    end

    // RX storage and registered head read (no reset so it maps onto RAM)
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r] <= bus.usb_rx_data;
        end
        rx_data_r <= rx_mem_r[rx_rd_sel_s];
    end

    // RX pointers, level, flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr_r <= {RX_AW{1'b0}};
            rx_rd_ptr_r <= {RX_AW{1'b0}};
            rx_level_r  <= RX_ZERO;
            rx_val_r    <= 1'b0;
            rx_rdy_r    <= 1'b1;
            rx_ovf_r    <= 1'b0;
        end else if (bus.flush) begin
            rx_wr_ptr_r <= {RX_AW{1'b0}};
            rx_rd_ptr_r <= {RX_AW{1'b0}};
            rx_level_r  <= RX_ZERO;
            rx_val_r    <= 1'b0;
            rx_rdy_r    <= 1'b1;
            rx_ovf_r    <= 1'b0;
        end else begin
            rx_wr_ptr_r <= rx_wr_ptr_r + RX_AW'(rx_push_s);
            rx_rd_ptr_r <= rx_rd_sel_s;
            rx_level_r  <= rx_level_nxt_s;
            // a byte written on this edge is only readable from RAM one edge later
            rx_val_r    <= (rx_old_s != RX_ZERO);
            rx_rdy_r    <= (rx_level_nxt_s != RX_FULL);
            rx_ovf_r    <= rx_ovf_r || (bus.usb_rx_val && (rx_level_r == RX_FULL));
        end
    end

    // TX handshake decode; an empty FIFO forwards the incoming byte so val never gaps in DRAIN
    always_comb begin
        tx_push_s      = bus.cpu_tx_val && (tx_level_r != TX_FULL) && !bus.flush;
        tx_pop_s       = bus.usb_tx_rdy && tx_val_r && !bus.flush;
        tx_old_s       = tx_level_r - (TX_AW+1)'(tx_pop_s);
        tx_level_nxt_s = tx_old_s + (TX_AW+1)'(tx_push_s);
        tx_rd_sel_s    = tx_rd_ptr_r + TX_AW'(tx_pop_s);
        tx_head_s      = (tx_old_s == TX_ZERO) ? bus.cpu_tx_data : tx_mem_r[tx_rd_sel_s];
    end

    // TX drain FSM next state
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        case (tx_state_r)
            ST_IDLE: begin
                if ((tx_level_r >= TX_BURST_L) || (tx_idle_cnt_r == TX_IDLE_L)) begin
                    tx_state_nxt_s = ST_DRAIN;
                end else begin
                    tx_state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (tx_level_nxt_s == TX_ZERO) begin
                    tx_state_nxt_s = ST_IDLE;
                end else begin
                    tx_state_nxt_s = ST_DRAIN;
                end
            end
            default: tx_state_nxt_s = ST_IDLE;
        endcase
    end

    // TX storage and registered head
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r] <= bus.cpu_tx_data;
        end
        tx_data_r <= tx_head_s;
    end

    // TX pointers, level, FSM state, idle counter, output flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr_r   <= {TX_AW{1'b0}};
            tx_rd_ptr_r   <= {TX_AW{1'b0}};
            tx_level_r    <= TX_ZERO;
            tx_val_r      <= 1'b0;
            tx_rdy_r      <= 1'b1;
            tx_idle_cnt_r <= 16'd0;
            tx_state_r    <= ST_IDLE;
        end else if (bus.flush) begin
            tx_wr_ptr_r   <= {TX_AW{1'b0}};
            tx_rd_ptr_r   <= {TX_AW{1'b0}};
            tx_level_r    <= TX_ZERO;
            tx_val_r      <= 1'b0;
            tx_rdy_r      <= 1'b1;
            tx_idle_cnt_r <= 16'd0;
            tx_state_r    <= ST_IDLE;
        end else begin
            tx_wr_ptr_r <= tx_wr_ptr_r + TX_AW'(tx_push_s);
            tx_rd_ptr_r <= tx_rd_sel_s;
            tx_level_r  <= tx_level_nxt_s;
            tx_val_r    <= (tx_state_nxt_s == ST_DRAIN) && (tx_level_nxt_s != TX_ZERO);
            tx_rdy_r    <= (tx_level_nxt_s != TX_FULL);
            tx_state_r  <= tx_state_nxt_s;
            if ((tx_state_r == ST_IDLE) && !tx_push_s && (tx_level_r != TX_ZERO)) begin
                tx_idle_cnt_r <= (tx_idle_cnt_r == TX_IDLE_L) ? tx_idle_cnt_r : tx_idle_cnt_r + 16'd1;
            end else begin
                tx_idle_cnt_r <= 16'd0;
            end
        end
    end

    assign bus.usb_rx_rdy  = rx_rdy_r;
    assign bus.cpu_rx_data = rx_data_r;
    assign bus.cpu_rx_val  = rx_val_r;
    assign bus.cpu_tx_rdy  = tx_rdy_r;
    assign bus.usb_tx_data = tx_data_r;
    assign bus.usb_tx_val  = tx_val_r;
    assign bus.rx_level    = rx_level_r;
    assign bus.tx_level    = tx_level_r;
    assign bus.rx_ovf      = rx_ovf_r;
endmodule
